// File: rtl/clk_pkg.sv
// Shared types and constants for the real-time clock alarm path.
package clk_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [HR_W-1:0]  HOURS_PER_DAY = 5'd24;
  localparam logic [MIN_W-1:0] MIN_PER_HOUR  = 6'd60;

  typedef enum logic [1:0] {
    ALARM_IDLE    = 2'd0,
    ALARM_ARMED   = 2'd1,
    ALARM_RINGING = 2'd2,
    ALARM_SNOOZE  = 2'd3
  } alarm_state_t;

  function automatic logic time_valid(input logic [HR_W-1:0] hours,
                                      input logic [MIN_W-1:0] minutes);
    return (hours < HOURS_PER_DAY) && (minutes < MIN_PER_HOUR);
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable seconds down-counter; expire pulses on the tick that would take count from 1 to 0.
module tick_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  assign expire = en && tick && (count == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm stage: stores alarm time, detects hh:mm:00, rings for RING_SEC and handles snooze/stop.
//
// state         | meaning
// ALARM_IDLE    | alarm disarmed (alarm_en low)
// ALARM_ARMED   | waiting for the alarm minute
// ALARM_RINGING | buzzer on, ring timer running
// ALARM_SNOOZE  | buzzer off, snooze timer running
module alarm_ctrl
  import clk_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tc_time_base,
  input  logic [SEC_W-1:0] q_seconds,
  input  logic [MIN_W-1:0] q_minutes,
  input  logic [HR_W-1:0]  q_hours,
  input  logic             alarm_en,
  input  logic             set_alarm,
  input  logic [HR_W-1:0]  set_hours,
  input  logic [MIN_W-1:0] set_minutes,
  input  logic             snooze,
  input  logic             stop,
  output logic [HR_W-1:0]  alarm_hours_out,
  output logic [MIN_W-1:0] alarm_minutes_out,
  output logic             buzzer,
  output logic             snoozing,
  output logic             set_err
);

  localparam int MAX_SEC = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CNT_W   = $clog2(MAX_SEC + 1);
  localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SEC);

  alarm_state_t     state, state_d;
  logic             match_now, match_prev, trigger;
  logic             set_valid;
  logic             tmr_load, tmr_en, tmr_expire;
  logic [CNT_W-1:0] tmr_load_val;

  assign match_now = (q_hours == alarm_hours_out) && (q_minutes == alarm_minutes_out)
                     && (q_seconds == '0);
  assign trigger   = match_now && !match_prev;
  assign set_valid = time_valid(set_hours, set_minutes);
  assign tmr_en    = (state == ALARM_RINGING) || (state == ALARM_SNOOZE);

  tick_timer #(
    .CNT_W(CNT_W)
  ) u_tick_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (tmr_en),
    .tick     (tc_time_base),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d      = state;
    tmr_load     = 1'b0;
    tmr_load_val = RING_LD;
    if (!alarm_en) begin
      state_d = ALARM_IDLE;
    end else if (set_alarm) begin
      // a rejected set leaves the state alone, including in IDLE
      if (set_valid) state_d = ALARM_ARMED;
    end else begin
      unique case (state)
        ALARM_IDLE: state_d = ALARM_ARMED;
        ALARM_ARMED: begin
          if (trigger) begin
            state_d  = ALARM_RINGING;
            tmr_load = 1'b1;
          end
        end
        ALARM_RINGING: begin
          if (stop) begin
            state_d = ALARM_ARMED;
          end else if (snooze) begin
            state_d      = ALARM_SNOOZE;
            tmr_load     = 1'b1;
            tmr_load_val = SNOOZE_LD;
          end else if (tmr_expire) begin
            state_d = ALARM_ARMED;
          end
        end
        ALARM_SNOOZE: begin
          if (stop) begin
            state_d = ALARM_ARMED;
          end else if (tmr_expire) begin
            state_d  = ALARM_RINGING;
            tmr_load = 1'b1;
          end
        end
        default: state_d = ALARM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ALARM_IDLE;
      match_prev <= 1'b0;
      buzzer     <= 1'b0;
      snoozing   <= 1'b0;
    end else begin
      state      <= state_d;
      match_prev <= match_now;
      buzzer     <= (state_d == ALARM_RINGING);
      snoozing   <= (state_d == ALARM_SNOOZE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_hours_out   <= '0;
      alarm_minutes_out <= '0;
      set_err           <= 1'b0;
    end else if (set_alarm) begin
      if (set_valid) begin
        alarm_hours_out   <= set_hours;
        alarm_minutes_out <= set_minutes;
        set_err           <= 1'b0;
      end else begin
        set_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with short ring/snooze periods.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tc_time_base = 1'b0;
  logic [5:0] q_seconds = '0;
  logic [5:0] q_minutes = '0;
  logic [4:0] q_hours = '0;
  logic       alarm_en = 1'b0;
  logic       set_alarm = 1'b0;
  logic [4:0] set_hours = '0;
  logic [5:0] set_minutes = '0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] alarm_hours_out;
  logic [5:0] alarm_minutes_out;
  logic       buzzer, snoozing, set_err;

  int errors = 0;
  int checks = 0;

  alarm_ctrl #(.RING_SEC(3), .SNOOZE_SEC(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .tc_time_base      (tc_time_base),
    .q_seconds         (q_seconds),
    .q_minutes         (q_minutes),
    .q_hours           (q_hours),
    .alarm_en          (alarm_en),
    .set_alarm         (set_alarm),
    .set_hours         (set_hours),
    .set_minutes       (set_minutes),
    .snooze            (snooze),
    .stop              (stop),
    .alarm_hours_out   (alarm_hours_out),
    .alarm_minutes_out (alarm_minutes_out),
    .buzzer            (buzzer),
    .snoozing          (snoozing),
    .set_err           (set_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tc_time_base = 1'b1;
    cyc();
    tc_time_base = 1'b0;
  endtask

  task automatic do_set(input logic [4:0] h, input logic [5:0] m);
    set_hours = h;
    set_minutes = m;
    set_alarm = 1'b1;
    cyc();
    set_alarm = 1'b0;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    q_hours = h;
    q_minutes = m;
    q_seconds = s;
  endtask

  initial begin
    #3 reset = 1'b0;
    cyc(2);
    chk("rst_buzzer", 32'(buzzer), 0);
    chk("rst_snoozing", 32'(snoozing), 0);
    chk("rst_set_err", 32'(set_err), 0);
    chk("rst_hours", 32'(alarm_hours_out), 0);
    chk("rst_minutes", 32'(alarm_minutes_out), 0);
    reset = 1'b1;
    set_time(5'd1, 6'd0, 6'd10);
    cyc();

    // arm and set 07:30
    alarm_en = 1'b1;
    do_set(5'd7, 6'd30);
    chk("set_hours", 32'(alarm_hours_out), 7);
    chk("set_minutes", 32'(alarm_minutes_out), 30);
    chk("set_err_clear", 32'(set_err), 0);

    set_time(5'd7, 6'd29, 6'd59);
    cyc(3);
    chk("pre_alarm_buzzer", 32'(buzzer), 0);
    set_time(5'd7, 6'd30, 6'd0);
    chk("same_cycle_buzzer", 32'(buzzer), 0);
    cyc();
    chk("trigger_buzzer", 32'(buzzer), 1);

    // ring for exactly 3 ticks, holding 07:30:00
    cyc(2);
    pulse_tick();
    chk("ring_tick1", 32'(buzzer), 1);
    cyc(2);
    pulse_tick();
    chk("ring_tick2", 32'(buzzer), 1);
    cyc(2);
    pulse_tick();
    chk("ring_autostop", 32'(buzzer), 0);
    cyc(5);
    chk("no_retrigger", 32'(buzzer), 0);
    chk("no_retrigger_snz", 32'(snoozing), 0);

    // leave and re-enter the alarm second to re-ring
    set_time(5'd7, 6'd30, 6'd1);
    cyc(2);
    set_time(5'd7, 6'd30, 6'd0);
    cyc();
    chk("reretrigger", 32'(buzzer), 1);
    pulse_tick();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    chk("snooze_buzzer", 32'(buzzer), 0);
    chk("snooze_flag", 32'(snoozing), 1);
    pulse_tick();
    pulse_tick();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    pulse_tick();
    pulse_tick();
    chk("snooze_4ticks_snz", 32'(snoozing), 1);
    chk("snooze_4ticks_buz", 32'(buzzer), 0);
    pulse_tick();
    chk("rering_buzzer", 32'(buzzer), 1);
    chk("rering_snoozing", 32'(snoozing), 0);
    stop = 1'b1;
    snooze = 1'b1;
    cyc();
    stop = 1'b0;
    snooze = 1'b0;
    chk("stop_wins_buzzer", 32'(buzzer), 0);
    chk("stop_wins_snoozing", 32'(snoozing), 0);
    cyc(3);
    chk("stop_stays_off", 32'(snoozing), 0);

    // invalid and valid sets
    do_set(5'd24, 6'd0);
    chk("bad_hour_err", 32'(set_err), 1);
    chk("bad_hour_keep_h", 32'(alarm_hours_out), 7);
    chk("bad_hour_keep_m", 32'(alarm_minutes_out), 30);
    do_set(5'd5, 6'd60);
    chk("bad_min_err", 32'(set_err), 1);
    chk("bad_min_keep_h", 32'(alarm_hours_out), 7);
    chk("bad_min_keep_m", 32'(alarm_minutes_out), 30);
    do_set(5'd23, 6'd59);
    chk("good_set_err", 32'(set_err), 0);
    chk("good_set_h", 32'(alarm_hours_out), 23);
    chk("good_set_m", 32'(alarm_minutes_out), 59);

    // midnight alarm with wrap
    do_set(5'd0, 6'd0);
    set_time(5'd23, 6'd59, 6'd59);
    cyc(3);
    chk("midnight_pre", 32'(buzzer), 0);
    set_time(5'd0, 6'd0, 6'd0);
    cyc();
    chk("midnight_ring", 32'(buzzer), 1);
    cyc(2);
    alarm_en = 1'b0;
    cyc();
    chk("disable_buzzer", 32'(buzzer), 0);
    chk("disable_snoozing", 32'(snoozing), 0);

    // async reset mid-snooze
    alarm_en = 1'b1;
    cyc();
    do_set(5'd12, 6'd34);
    set_time(5'd12, 6'd33, 6'd59);
    cyc(2);
    set_time(5'd12, 6'd34, 6'd0);
    cyc();
    chk("ring_1234", 32'(buzzer), 1);
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    chk("snooze_1234", 32'(snoozing), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_snoozing", 32'(snoozing), 0);
    chk("async_rst_buzzer", 32'(buzzer), 0);
    chk("async_rst_hours", 32'(alarm_hours_out), 0);
    chk("async_rst_minutes", 32'(alarm_minutes_out), 0);
    chk("async_rst_err", 32'(set_err), 0);
    cyc(2);
    reset = 1'b1;
    cyc(2);
    chk("post_rst_buzzer", 32'(buzzer), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
